keypad_matrix_scanner: RTL
==========================

// Module: keypad_matrix_scanner
// PURPOSE
//   Input-side counterpart of the time-multiplexed 4-digit display driver: scans a 4x4
//   matrix keypad one column at a time, debounces, and reports one key code {row,col}
//   per press. row/col feed the ID-entry FSM, with the same encoding the display driver
//   uses to echo the ID. key_valid is the single-cycle "ID entered" strobe.
// PARAMETERS
//   SCAN_DIV        8192  clk cycles per column slot; column drive is held for this long
//   DEBOUNCE_SCANS  4     consecutive full scans with an identical result to accept press/release
// PORTS
//   clk         in   1  system clock
//   rst         in   1  synchronous reset, active-high
//   row_sense   in   4  keypad rows, active-low (0 = key closed on driven column)
//   col_drive   out  4  keypad columns, active-low, exactly one bit low at all times
//   row         out  2  row index of accepted key (0..3); held until next accepted key
//   col         out  2  column index of accepted key (0..3); held until next accepted key
//   key_valid   out  1  one-clk pulse when a press is accepted
//   key_held    out  1  level, 1 from accepted press until debounced release
//   multi_key   out  1  level, 1 while the last completed scan saw more than one closed key
// BEHAVIOUR
//   Reset (rst=1 at posedge), all registered:
//     col_drive=4'b1110; div_cnt=0; col_idx=0; state=IDLE; row=col=0;
//     key_valid=key_held=multi_key=0; debounce count and scan accumulator cleared.
//   Scan timing:
//     - div_cnt counts 0..SCAN_DIV-1. At div_cnt==SCAN_DIV-1, row_sense is sampled for
//       column col_idx; on the same edge col_idx advances (3 wraps to 0) and
//       col_drive = ~(1<<next col_idx).
//     - Full scan = 4*SCAN_DIV cycles. Scan end = the sample edge of column 3.
//     - Scan result is NONE, SINGLE(r,c) or MULTI (>1 closed contact, any columns).
//       r = index of the low row_sense bit; c = col_idx at sampling.
//   State machine, evaluated only at scan end (no change on other edges):
//     IDLE    SINGLE(k) -> DEBOUNCE, cand=k, cnt=1; NONE/MULTI -> stay.
//     DEBOUNCE SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> PRESSED,
//             row/col<=cand, key_valid=1 for exactly the next clk cycle, key_held=1.
//             Any other result -> IDLE, cnt=0.
//     PRESSED NONE -> RELEASE, cnt=1; SINGLE(any)/MULTI -> stay (no auto-repeat, no new pulse).
//     RELEASE NONE -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> IDLE, key_held=0.
//             SINGLE/MULTI -> PRESSED, cnt=0.
//   - DEBOUNCE_SCANS=1: press is accepted at the first scan end that sees the key.
//   - multi_key is updated at every scan end: 1 on MULTI, 0 otherwise.
//     It is independent of state.
//   - Latency: press stable from the start of scan n -> key_valid high in the cycle after
//     the end of scan n+DEBOUNCE_SCANS-1.
//   - rst mid-operation: all state is discarded. A key still held after reset must pass
//     full debounce from IDLE and produces a new key_valid.
//   - row_sense is asynchronous: double-flop it before sampling. Synchronizer latency
//     (2 clk) must be < SCAN_DIV. Require SCAN_DIV >= 4.
// TESTING  (bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2; scan = 16 clk)
//   1. rst=1 for 3 clk, row_sense=4'hF -> col_drive=1110 and all outputs 0. After rst=0,
//      col_drive steps 1101,1011,0111,1110 every 4 clk.
//   2. Close key r2/c1 (row_sense[2]=0 while col_drive[1]=0) for 5 scans -> exactly one
//      key_valid pulse, 32 clk after the start of the first full scan; row=2, col=1,
//      key_held=1. Open the key -> key_held=0 after 2 empty scans, no second pulse.
//   3. Bounce: r0/c3 present 1 scan, absent 1 scan, repeated 4 times -> key_valid never 1,
//      key_held stays 0.
//   4. r0/c0 and r3/c3 closed together -> multi_key=1 at first scan end, no key_valid.
//      Release both -> multi_key=0 at next scan end.
//   5. Hold r1/c2 until accepted, then additionally close r1/c0 -> multi_key=1, no new
//      pulse, row/col remain 1/2.
//   6. r3/c0 held, rst pulsed after 1 scan (mid-DEBOUNCE) -> no pulse before reset; exactly
//      one pulse 2 full scans after reset release.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, classifies each full
// scan as none/single/multi, debounces press and release, and reports one code per press.
module keypad_matrix_scanner #(
  parameter int unsigned SCAN_DIV       = 8192,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_sense,
  output logic [3:0] col_drive,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 4");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("DEBOUNCE_SCANS must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } res_e;

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_drive_q, col_drive_d;
  res_e             acc_res_q, acc_res_d;
  logic [1:0]       acc_row_q, acc_row_d;
  logic [1:0]       acc_col_q, acc_col_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cand_row_q, cand_row_d;
  logic [1:0]       cand_col_q, cand_col_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             multi_key_q, multi_key_d;

  logic             sample;
  logic             scan_end;
  logic [3:0]       closed;
  logic [2:0]       col_hits;
  logic [1:0]       col_row;
  res_e             merged_res;
  logic [1:0]       merged_row;
  logic [1:0]       merged_col;
  logic             same_cand;
  logic [CNT_W-1:0] cnt_inc;

  assign sync1_d  = row_sense;
  assign sync2_d  = sync1_q;
  assign sample   = (div_cnt_q == DIV_LAST);
  assign scan_end = sample && (col_idx_q == 2'd3);
  assign closed   = ~sync2_q;

  always_comb begin
    col_hits = '0;
    col_row  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (closed[i]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(i);
      end
    end
  end

  // Fold the current column into the running scan result; a second contact anywhere
  // in the scan (same column or a different one) makes the scan MULTI.
  always_comb begin
    merged_res = acc_res_q;
    merged_row = acc_row_q;
    merged_col = acc_col_q;
    if (col_hits > 3'd1) begin
      merged_res = RES_MULTI;
    end else if (col_hits == 3'd1) begin
      if (acc_res_q == RES_NONE) begin
        merged_res = RES_SINGLE;
        merged_row = col_row;
        merged_col = col_idx_q;
      end else begin
        merged_res = RES_MULTI;
      end
    end
  end

  always_comb begin
    div_cnt_d   = div_cnt_q + DIV_W'(1);
    col_idx_d   = col_idx_q;
    acc_res_d   = acc_res_q;
    acc_row_d   = acc_row_q;
    acc_col_d   = acc_col_q;
    if (sample) begin
      div_cnt_d = '0;
      col_idx_d = col_idx_q + 2'd1;
      if (scan_end) begin
        acc_res_d = RES_NONE;
        acc_row_d = '0;
        acc_col_d = '0;
      end else begin
        acc_res_d = merged_res;
        acc_row_d = merged_row;
        acc_col_d = merged_col;
      end
    end
    col_drive_d = ~(4'b0001 << col_idx_d);
  end

  assign same_cand = (merged_res == RES_SINGLE) && (merged_row == cand_row_q) &&
                     (merged_col == cand_col_q);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    row_d       = row_q;
    col_d       = col_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_key_d = multi_key_q;
    if (scan_end) begin
      multi_key_d = (merged_res == RES_MULTI);
      case (state_q)
        ST_IDLE: begin
          if (merged_res == RES_SINGLE) begin
            cand_row_d = merged_row;
            cand_col_d = merged_col;
            if (CNT_ONE == CNT_DONE) begin
              state_d     = ST_PRESSED;
              cnt_d       = '0;
              row_d       = merged_row;
              col_d       = merged_col;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (same_cand) begin
            if (cnt_inc == CNT_DONE) begin
              state_d     = ST_PRESSED;
              cnt_d       = '0;
              row_d       = cand_row_q;
              col_d       = cand_col_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          if (merged_res == RES_NONE) begin
            if (CNT_ONE == CNT_DONE) begin
              state_d    = ST_IDLE;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_RELEASE: begin
          if (merged_res == RES_NONE) begin
            if (cnt_inc == CNT_DONE) begin
              state_d    = ST_IDLE;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      div_cnt_q   <= '0;
      col_idx_q   <= '0;
      col_drive_q <= 4'b1110;
      acc_res_q   <= RES_NONE;
      acc_row_q   <= '0;
      acc_col_q   <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_row_q  <= '0;
      cand_col_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      div_cnt_q   <= div_cnt_d;
      col_idx_q   <= col_idx_d;
      col_drive_q <= col_drive_d;
      acc_res_q   <= acc_res_d;
      acc_row_q   <= acc_row_d;
      acc_col_q   <= acc_col_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      row_q       <= row_d;
      col_q       <= col_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
    end
  end

  assign col_drive = col_drive_q;
  assign row       = row_q;
  assign col       = col_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;

endmodule
